// File: rtl/qs_enq.sv
// Quicksort ingress stage: loads SOP/EOP-framed words into the owned bank
// and publishes LOADING/LOADED to the bank scoreboard, then rotates banks.
package qs_pkg;
  parameter int W = 32;

  typedef enum logic [2:0] {
    S_FREE    = 3'd0,
    S_READY   = 3'd1,
    S_LOADING = 3'd2,
    S_LOADED  = 3'd3,
    S_SORTING = 3'd4,
    S_DONE    = 3'd5
  } status_t;
endpackage

module qs_enq #(
  parameter int W     = qs_pkg::W,
  parameter int N     = 256,
  parameter int BANKS = 2,
  localparam int AW   = $clog2(N),
  localparam int IDW  = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int SW   = 3 + AW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_vld,
  input  logic           in_sop,
  input  logic           in_eop,
  input  logic [W-1:0]   in_dat,
  output logic           in_rdy_r,
  output logic [IDW-1:0] bank_idx_r,
  input  logic [SW-1:0]  bank_in_r,
  output logic           bank_out_vld_r,
  output logic [SW-1:0]  bank_out_r,
  output logic           wr_en_r,
  output logic [AW-1:0]  wr_addr_r,
  output logic [W-1:0]   wr_data_r
);
  import qs_pkg::*;

  typedef struct packed {
    logic [2:0]    status;
    logic [AW-1:0] n;
    logic          err;
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n, addr_inc;
  logic          err, err_n;
  logic          acc, ovf;
  logic          rdy_n, we_n, sv_n;
  logic [AW-1:0] wa_n;
  logic [W-1:0]  wd_n;
  logic [IDW-1:0] idx_n;
  bank_state_t   bin, so_n;

  assign bin      = bank_state_t'(bank_in_r);
  assign acc      = in_vld & in_rdy_r;
  assign addr_inc = addr + AW'(1);

  // next-state, write and scoreboard decisions for this beat
  always_comb begin
    state_n = state;
    rdy_n   = in_rdy_r;
    addr_n  = addr;
    err_n   = err;
    ovf     = 1'b0;
    we_n    = 1'b0;
    wa_n    = wr_addr_r;
    wd_n    = wr_data_r;
    sv_n    = 1'b0;
    so_n    = bank_state_t'(bank_out_r);
    idx_n   = bank_idx_r;
    unique case (state)
      IDLE: begin
        rdy_n = (bin.status == S_READY);
        if (acc && in_sop) begin
          addr_n   = '0;
          err_n    = 1'b0;
          we_n     = 1'b1;
          wa_n     = '0;
          wd_n     = in_dat;
          sv_n     = 1'b1;
          so_n     = bin;
          so_n.n   = '0;
          so_n.err = 1'b0;
          if (in_eop) begin
            so_n.status = S_LOADED;
            state_n     = COMMIT;
            rdy_n       = 1'b0;
          end else begin
            so_n.status = S_LOADING;
            state_n     = LOAD;
            rdy_n       = 1'b1;
          end
        end
      end
      LOAD: begin
        rdy_n = 1'b1;
        if (acc) begin
          ovf   = (addr == AW'(N - 1));
          err_n = err | ovf | in_sop;
          if (!ovf) begin
            addr_n = addr_inc;
            we_n   = 1'b1;
            wa_n   = addr_inc;
            wd_n   = in_dat;
          end
          if (in_eop) begin
            sv_n        = 1'b1;
            so_n        = bin;
            so_n.status = S_LOADED;
            so_n.n      = addr_n;
            so_n.err    = err_n;
            state_n     = COMMIT;
            rdy_n       = 1'b0;
          end
        end
      end
      COMMIT: begin
        rdy_n   = 1'b0;
        state_n = IDLE;
        if (bank_idx_r == IDW'(BANKS - 1)) begin
          idx_n = '0;
        end else begin
          idx_n = bank_idx_r + IDW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        rdy_n   = 1'b0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      addr           <= '0;
      err            <= 1'b0;
      in_rdy_r       <= 1'b0;
      bank_idx_r     <= '0;
      bank_out_vld_r <= 1'b0;
      bank_out_r     <= '0;
      wr_en_r        <= 1'b0;
      wr_addr_r      <= '0;
      wr_data_r      <= '0;
    end else begin
      state          <= state_n;
      addr           <= addr_n;
      err            <= err_n;
      in_rdy_r       <= rdy_n;
      bank_idx_r     <= idx_n;
      bank_out_vld_r <= sv_n;
      bank_out_r     <= so_n;
      wr_en_r        <= we_n;
      wr_addr_r      <= wa_n;
      wr_data_r      <= wd_n;
    end
  end
endmodule

// File: tb/tb_qs_enq.sv
// Directed bench for qs_enq with N=4, BANKS=2.
// Bench drives scoreboard status per bank; monitors log writes/strobes.
module tb_qs_enq;
  import qs_pkg::*;

  localparam int N     = 4;
  localparam int BANKS = 2;
  localparam int AW    = 2;
  localparam int SW    = 6;

  logic          clk, rst;
  logic          in_vld, in_sop, in_eop;
  logic [31:0]   in_dat;
  logic          in_rdy_r;
  logic [0:0]    bank_idx_r;
  logic [SW-1:0] bank_in_r;
  logic          bank_out_vld_r;
  logic [SW-1:0] bank_out_r;
  logic          wr_en_r;
  logic [AW-1:0] wr_addr_r;
  logic [31:0]   wr_data_r;

  logic [2:0]    bstat [BANKS];
  int            total, bad, acc_cnt;
  int            wa_q [$];
  logic [31:0]   wd_q [$];
  logic [SW-1:0] sb_q [$];

  qs_enq #(.W(32), .N(N), .BANKS(BANKS)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_dat(in_dat),
    .in_rdy_r(in_rdy_r), .bank_idx_r(bank_idx_r), .bank_in_r(bank_in_r),
    .bank_out_vld_r(bank_out_vld_r), .bank_out_r(bank_out_r),
    .wr_en_r(wr_en_r), .wr_addr_r(wr_addr_r), .wr_data_r(wr_data_r)
  );

  always #5 clk = ~clk;

  assign bank_in_r = {bstat[bank_idx_r], 3'b000};

  // log memory writes and scoreboard strobes
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_r) begin
        wa_q.push_back(int'(wr_addr_r));
        wd_q.push_back(wr_data_r);
      end
      if (bank_out_vld_r) sb_q.push_back(bank_out_r);
    end
  end

  // count accepted beats
  always @(posedge clk) begin
    if (!rst && in_vld && in_rdy_r) acc_cnt++;
  end

  function automatic logic [SW-1:0] sb(input logic [2:0] s,
                                       input int n, input logic e);
    return {s, AW'(n), e};
  endfunction

  task automatic send(input logic s, input logic e, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_vld = 1'b1; in_sop = s; in_eop = e; in_dat = d;
    while (!in_rdy_r && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL send_timeout rdy=%0b required=1", in_rdy_r);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    wait_cyc(2);
    total++;
    if (in_rdy_r !== 1'b0) begin bad++;
      $display("FAIL rst_rdy got=%0b exp=0", in_rdy_r); end
    total++;
    if (bank_idx_r !== 1'b0) begin bad++;
      $display("FAIL rst_idx got=%0d exp=0", bank_idx_r); end
    total++;
    if (bank_out_vld_r !== 1'b0 || bank_out_r !== '0) begin bad++;
      $display("FAIL rst_sb got=%0b/%h exp=0/0", bank_out_vld_r, bank_out_r); end
    total++;
    if (wr_en_r !== 1'b0 || wr_addr_r !== '0 || wr_data_r !== '0) begin bad++;
      $display("FAIL rst_wr got=%0b/%0d/%h exp=0/0/0",
               wr_en_r, wr_addr_r, wr_data_r); end
    rst = 1'b0;
  endtask

  task automatic test_four_word();
    logic [31:0] ex [4];
    int b, sbb;
    ex = '{32'd5, 32'd3, 32'd9, 32'd1};
    b = wa_q.size(); sbb = sb_q.size();
    send(1, 0, 5); send(0, 0, 3); send(0, 0, 9); send(0, 1, 1);
    idle();
    total++;
    if (in_rdy_r !== 1'b0) begin bad++;
      $display("FAIL four_rdy_commit got=%0b exp=0", in_rdy_r); end
    @(negedge clk);
    total++;
    if (in_rdy_r !== 1'b0) begin bad++;
      $display("FAIL four_rdy_idle got=%0b exp=0", in_rdy_r); end
    wait_cyc(2);
    total++;
    if (wa_q.size() - b != 4) begin bad++;
      $display("FAIL four_nwr got=%0d exp=4", wa_q.size() - b); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wa_q[b+i] != i || wd_q[b+i] !== ex[i]) begin bad++;
        $display("FAIL four_wr%0d got=%0d/%0d exp=%0d/%0d",
                 i, wa_q[b+i], wd_q[b+i], i, ex[i]); end
    end
    total++;
    if (sb_q.size() - sbb != 2 || sb_q[sbb] !== sb(S_LOADING, 0, 0)
        || sb_q[sbb+1] !== sb(S_LOADED, 3, 0)) begin bad++;
      $display("FAIL four_sb got=%0d:%h,%h exp=2:%h,%h", sb_q.size() - sbb,
               sb_q[sbb], sb_q[sbb+1], sb(S_LOADING, 0, 0), sb(S_LOADED, 3, 0));
    end
    total++;
    if (bank_idx_r !== 1'b1) begin bad++;
      $display("FAIL four_idx got=%0d exp=1", bank_idx_r); end
  endtask

  task automatic test_single();
    int b, sbb;
    b = wa_q.size(); sbb = sb_q.size();
    send(1, 1, 32'h7);
    idle(); wait_cyc(3);
    total++;
    if (wa_q.size() - b != 1 || wa_q[b] != 0 || wd_q[b] !== 32'h7) begin bad++;
      $display("FAIL single_wr got=%0d@%0d=%h exp=1@0=7",
               wa_q.size() - b, wa_q[b], wd_q[b]); end
    total++;
    if (sb_q.size() - sbb != 1 || sb_q[sbb] !== sb(S_LOADED, 0, 0)) begin bad++;
      $display("FAIL single_sb got=%0d:%h exp=1:%h",
               sb_q.size() - sbb, sb_q[sbb], sb(S_LOADED, 0, 0)); end
    total++;
    if (bank_idx_r !== 1'b0) begin bad++;
      $display("FAIL single_idx got=%0d exp=0", bank_idx_r); end
  endtask

  task automatic test_not_ready();
    int b;
    bstat[0] = S_SORTING;
    wait_cyc(2);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (in_rdy_r !== 1'b0) begin bad++;
        $display("FAIL busy_rdy%0d got=%0b exp=0", i, in_rdy_r); end
      @(negedge clk);
    end
    bstat[0] = S_READY;
    b = wa_q.size();
    send(1, 0, 32'hA); send(0, 1, 32'hB);
    idle(); wait_cyc(3);
    total++;
    if (wa_q.size() - b != 2 || wa_q[b+1] != 1 || wd_q[b] !== 32'hA
        || wd_q[b+1] !== 32'hB) begin bad++;
      $display("FAIL busy_wr got=%0d %h,%h exp=2 a,b",
               wa_q.size() - b, wd_q[b], wd_q[b+1]); end
    total++;
    if (sb_q[sb_q.size()-1] !== sb(S_LOADED, 1, 0)) begin bad++;
      $display("FAIL busy_sb got=%h exp=%h",
               sb_q[sb_q.size()-1], sb(S_LOADED, 1, 0)); end
    total++;
    if (bank_idx_r !== 1'b1) begin bad++;
      $display("FAIL busy_idx got=%0d exp=1", bank_idx_r); end
  endtask

  task automatic test_overflow();
    int b, sbb, a0;
    b = wa_q.size(); sbb = sb_q.size(); a0 = acc_cnt;
    send(1, 0, 1); send(0, 0, 2); send(0, 0, 3);
    send(0, 0, 4); send(0, 0, 5); send(0, 1, 6);
    idle(); wait_cyc(3);
    total++;
    if (acc_cnt - a0 != 6) begin bad++;
      $display("FAIL ovf_acc got=%0d exp=6", acc_cnt - a0); end
    total++;
    if (wa_q.size() - b != 4) begin bad++;
      $display("FAIL ovf_nwr got=%0d exp=4", wa_q.size() - b); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wa_q[b+i] != i || wd_q[b+i] !== 32'(i + 1)) begin bad++;
        $display("FAIL ovf_wr%0d got=%0d/%0d exp=%0d/%0d",
                 i, wa_q[b+i], wd_q[b+i], i, i + 1); end
    end
    total++;
    if (sb_q.size() - sbb != 2 || sb_q[sbb+1] !== sb(S_LOADED, 3, 1)) begin bad++;
      $display("FAIL ovf_sb got=%0d:%h exp=2:%h",
               sb_q.size() - sbb, sb_q[sbb+1], sb(S_LOADED, 3, 1)); end
    total++;
    if (bank_idx_r !== 1'b0) begin bad++;
      $display("FAIL ovf_idx got=%0d exp=0", bank_idx_r); end
  endtask

  task automatic test_sop_in_load();
    int b;
    b = wa_q.size();
    send(1, 0, 32'h21); send(1, 0, 32'h22); send(0, 1, 32'h23);
    idle(); wait_cyc(3);
    total++;
    if (wa_q.size() - b != 3 || wa_q[b+2] != 2 || wd_q[b+1] !== 32'h22
        || wd_q[b+2] !== 32'h23) begin bad++;
      $display("FAIL sop_wr got=%0d last=%0d:%h exp=3 last=2:23",
               wa_q.size() - b, wa_q[b+2], wd_q[b+2]); end
    total++;
    if (sb_q[sb_q.size()-1] !== sb(S_LOADED, 2, 1)) begin bad++;
      $display("FAIL sop_sb got=%h exp=%h",
               sb_q[sb_q.size()-1], sb(S_LOADED, 2, 1)); end
  endtask

  task automatic test_stray();
    int b, sbb;
    b = wa_q.size(); sbb = sb_q.size();
    send(0, 0, 32'h11); send(0, 1, 32'h12);
    idle(); wait_cyc(2);
    total++;
    if (wa_q.size() != b || sb_q.size() != sbb) begin bad++;
      $display("FAIL stray_drop got=%0d wr %0d sb exp=0 0",
               wa_q.size() - b, sb_q.size() - sbb); end
    send(1, 0, 32'h33); send(0, 1, 32'h44);
    idle(); wait_cyc(3);
    total++;
    if (wa_q.size() - b != 2 || wa_q[b] != 0 || wd_q[b] !== 32'h33
        || wd_q[b+1] !== 32'h44) begin bad++;
      $display("FAIL stray_wr got=%0d %0d:%h exp=2 0:33",
               wa_q.size() - b, wa_q[b], wd_q[b]); end
    total++;
    if (sb_q[sb_q.size()-1] !== sb(S_LOADED, 1, 0)) begin bad++;
      $display("FAIL stray_sb got=%h exp=%h",
               sb_q[sb_q.size()-1], sb(S_LOADED, 1, 0)); end
    total++;
    if (bank_idx_r !== 1'b0) begin bad++;
      $display("FAIL stray_idx got=%0d exp=0", bank_idx_r); end
  endtask

  task automatic test_back_to_back();
    send(1, 0, 1); send(0, 1, 2);
    send(1, 0, 3);
    total++;
    if (bank_idx_r !== 1'b1) begin bad++;
      $display("FAIL b2b_idx1 got=%0d exp=1", bank_idx_r); end
    send(0, 1, 4);
    send(1, 0, 5);
    total++;
    if (bank_idx_r !== 1'b0) begin bad++;
      $display("FAIL b2b_idx0 got=%0d exp=0", bank_idx_r); end
    send(0, 0, 6);
    @(negedge clk);
    total++;
    if (wr_en_r !== 1'b1 || wr_addr_r !== 2'd1) begin bad++;
      $display("FAIL b2b_prerst got=%0b@%0d exp=1@1", wr_en_r, wr_addr_r); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (in_rdy_r !== 1'b0 || bank_idx_r !== 1'b0 || bank_out_vld_r !== 1'b0)
    begin bad++;
      $display("FAIL midrst_ctl got=%0b/%0d/%0b exp=0/0/0",
               in_rdy_r, bank_idx_r, bank_out_vld_r); end
    total++;
    if (bank_out_r !== '0 || wr_en_r !== 1'b0 || wr_addr_r !== '0
        || wr_data_r !== '0) begin bad++;
      $display("FAIL midrst_dat got=%h/%0b/%0d/%h exp=0/0/0/0",
               bank_out_r, wr_en_r, wr_addr_r, wr_data_r); end
    @(negedge clk);
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    rst = 1'b0;
    wait_cyc(2);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_dat = '0;
    bstat[0] = S_READY; bstat[1] = S_READY;
    total = 0; bad = 0; acc_cnt = 0;
    test_reset();
    test_four_word();
    test_single();
    test_not_ready();
    test_overflow();
    test_sop_in_load();
    test_stray();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
